parity_seq_ctrl: RTL
====================

Name: parity_seq_ctrl

Overview:
Sequential parity controller for the ALU parity path. It accepts a WIDTH-bit word over a valid/ready handshake. It then reduces the word 4 bits per cycle through a single shared xor4 instance and returns the even or odd parity bit over a second valid/ready handshake. This trades latency for area against a full-width XOR tree, and feeds the ALU flag logic.

Parameters:
WIDTH, 32, operand width; must be a multiple of 4 and at least 4.
NIB (localparam), WIDTH/4, number of nibble-reduction cycles.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand valid
in_ready  output  1  controller can accept an operand
in_data  input  WIDTH  operand word
odd_mode  input  1  0 = XOR of all bits; 1 = inverted XOR; sampled at acceptance
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_parity  output  1  parity result
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, shift register=0, accumulator=0, counter=0, mode register=0.
- Output values in reset: out_valid=0, out_parity=0, busy=0, in_ready=1 (in_ready is decoded from IDLE).
- States: IDLE, RUN, DONE. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: shreg<=in_data, mode<=odd_mode, acc<=0, cnt<=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: acc<=acc^xor4(shreg[3:0]), shreg<=shreg>>4, cnt<=cnt+1.
  - When cnt==NIB-1, the final nibble is folded and the state goes to DONE.
  - Exactly NIB cycles in RUN.
- DONE:
  - out_valid=1, out_parity=acc^mode.
  - Values are held stable until out_ready=1. On that edge the state goes to IDLE and out_valid drops.
- Latency: if the handshake occurs at edge E0, out_valid is visible after edge E0+NIB (8 cycles for WIDTH=32).
- Throughput: one word per NIB+2 cycles minimum. There is no accept in the same cycle as a DONE release; IDLE is always visited.
- in_valid and in_data are ignored outside IDLE. Operand changes during RUN do not affect the result.
- out_ready is ignored outside DONE.
- WIDTH=4: NIB=1, so RUN lasts one cycle and the counter width is clamped to at least 1 bit.
- Reset mid-RUN or mid-DONE aborts the operation immediately: no result is produced, and the first post-reset accept starts clean.
- out_parity holds its last value (0 after reset) outside DONE. Consumers must qualify it with out_valid.

Decomposition:
- Package alu_pkg:
  - state encodings IDLE=2'b00, RUN=2'b01, DONE=2'b10
  - NIBBLE_W=4
  - helper function for counter width (clog2 clamped to at least 1)
- One sub-module: the existing xor4 gate, instantiated once on shreg[3:0] as the nibble reducer.
- FSM, counter, shift register and accumulator stay in parity_seq_ctrl.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles, release -> out_valid=0, busy=0, in_ready=1, out_parity=0. Assert rst_n asynchronously mid-cycle -> outputs clear without a clock edge.
2. WIDTH=32, in_data=32'h0000_0001, odd_mode=0, out_ready=1 -> in_ready=0 next cycle; out_valid=1 exactly 8 cycles after acceptance with out_parity=1; IDLE one cycle later.
3. in_data=32'hFFFF_FFFF, odd_mode=1 -> out_parity=1. Repeat with 32'h1234_5678, odd_mode=0 -> out_parity=1 (13 ones).
4. Backpressure: in_data=32'h0000_0003, out_ready=0 for 5 cycles in DONE -> out_valid=1 and out_parity=0 stable, in_ready=0, second in_valid pulse not accepted. Raise out_ready -> IDLE next edge; the pending operand is accepted on the following edge.
5. Operand isolation: accept 32'h0000_0001, then drive in_data=32'hFFFF_FFFE and toggle odd_mode during RUN -> result still 1 after 8 cycles.
6. Abort: reset at RUN cycle 3 -> no out_valid. Then accept 32'h8000_0000 with odd_mode=0 -> out_parity=1 after 8 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU parity path.
package alu_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Counter width for n steps; a single step still needs one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xor4.sv
// Four-input XOR reduction gate used as the shared nibble reducer.
module xor4 (
  input  logic [3:0] i_d,
  output logic       o_y
);

  assign o_y = ^i_d;

endmodule

// File: rtl/parity_seq_ctrl.sv
// Sequential parity controller: folds a WIDTH-bit operand one nibble per cycle
// through a single xor4 and returns even/odd parity over a valid/ready handshake.
module parity_seq_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             odd_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_parity,
  output logic             busy
);

  localparam int unsigned NIB   = WIDTH / NIBBLE_W;
  localparam int unsigned CNT_W = cnt_width(NIB);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("parity_seq_ctrl: WIDTH must be a non-zero multiple of 4");
  end

  state_e             r_state;
  state_e             w_next_state;
  logic [WIDTH-1:0]   r_shreg;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_acc;
  logic               r_mode;
  logic               r_parity;

  logic               w_nib_par;
  logic               w_fold;
  logic               w_last;
  logic               w_accept;
  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_busy;

  xor4 u_xor4 (
    .i_d (r_shreg[NIBBLE_W-1:0]),
    .o_y (w_nib_par)
  );

  assign w_fold   = r_acc ^ w_nib_par;
  assign w_last   = (r_cnt == CNT_W'(NIB - 1));
  assign w_accept = in_valid && w_in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; IDLE is always revisited between operands
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = RUN;
      RUN:     if (w_last) w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state only
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      IDLE:    w_in_ready = 1'b1;
      RUN:     w_busy = 1'b1;
      DONE:    begin
        w_out_valid = 1'b1;
        w_busy      = 1'b1;
      end
      default: w_in_ready = 1'b0;
    endcase
  end

  // Operand capture and nibble-serial fold; result latched on the last fold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg  <= '0;
      r_cnt    <= '0;
      r_acc    <= 1'b0;
      r_mode   <= 1'b0;
      r_parity <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shreg <= in_data;
            r_mode  <= odd_mode;
            r_acc   <= 1'b0;
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_acc   <= w_fold;
          r_shreg <= r_shreg >> NIBBLE_W;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (w_last) r_parity <= w_fold ^ r_mode;
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = w_out_valid;
  assign busy       = w_busy;
  assign out_parity = r_parity;

endmodule
